// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// port and a periodic display-refresh reader that fetches one fixed word.
// Optional build macro DMEM_ARB_STARVE_GUARD_EN adds a starvation counter that
// forces a display grant after STARVE_LIMIT waiting cycles; without it the CPU
// has strict priority.
module dmem_arbiter #(
  parameter int ADDR_W         = 4,
  parameter int REFRESH_CYCLES = 1024,
  parameter int STARVE_LIMIT   = 8,
  parameter int DISP_ADDR      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       disp_word,
  output logic              disp_update
);

  localparam int DATA_W  = 32;
  localparam int TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  DISP_WADDR = ADDR_W'(DISP_ADDR);

  // Reject configurations the refresh timer and starve counter cannot support.
  if (REFRESH_CYCLES < 4 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("dmem_arbiter: need REFRESH_CYCLES >= 4 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_DONE  = 2'd1,
    DISP_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TIMER_W-1:0]  timer;
  logic                timer_wrap;
  logic                disp_pending;
  logic                forced;
  logic                cpu_grant;
  logic                disp_grant;
  logic [DATA_W-1:0]   disp_word_q;

  assign timer_wrap = (timer == TIMER_LAST);

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Arbitration, memory strobes and completion outputs. Everything is gated
  // by reset so no access or completion pulse escapes while reset is high.
  always_comb begin
    state_next  = state;
    cpu_grant   = 1'b0;
    disp_grant  = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    disp_update = 1'b0;
    disp_word   = disp_word_q;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (disp_pending && forced) disp_grant = 1'b1;
          else if (cpu_req)           cpu_grant  = 1'b1;
          else if (disp_pending)      disp_grant = 1'b1;

          if (cpu_grant) begin
            mem_en     = 1'b1;
            mem_we     = cpu_we;
            state_next = CPU_DONE;
          end else if (disp_grant) begin
            mem_en     = 1'b1;
            mem_addr   = DISP_WADDR;
            state_next = DISP_DONE;
          end
        end
        CPU_DONE: begin
          // Memory data arrives one cycle after the grant; for stores it is
          // simply ignored by the CPU.
          cpu_ready  = 1'b1;
          cpu_rdata  = mem_rdata;
          state_next = IDLE;
        end
        DISP_DONE: begin
          // Present the fresh word in the same cycle as the update pulse.
          disp_update = 1'b1;
          disp_word   = mem_rdata;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Free-running refresh period counter.
  always_ff @(posedge clk) begin
    if (reset)           timer <= '0;
    else if (timer_wrap) timer <= '0;
    else                 timer <= timer + 1'b1;
  end

  // One outstanding refresh request; a wrap wins over a same-cycle grant so
  // that period is not lost, and extra wraps are absorbed.
  always_ff @(posedge clk) begin
    if (reset)           disp_pending <= 1'b0;
    else if (timer_wrap) disp_pending <= 1'b1;
    else if (disp_grant) disp_pending <= 1'b0;
  end

  // Holding register for the display word between refreshes.
  always_ff @(posedge clk) begin
    if (reset)            disp_word_q <= '0;
    else if (disp_update) disp_word_q <= mem_rdata;
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  // Count cycles the display has waited; saturate so forcing stays asserted.
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (disp_grant)
      starve_cnt <= '0;
    else if (disp_pending && (starve_cnt != STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign forced = (starve_cnt == STARVE_MAX);
`else
  // Strict CPU priority: the display only uses cycles the CPU leaves idle.
  assign forced = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a 16-cycle refresh
// period, a small behavioural memory and hand-computed expectations. Works
// with and without DMEM_ARB_STARVE_GUARD_EN defined.
module tb_dmem_arbiter;

  localparam int ADDR_W = 4;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int EXP_FIRST_DISP = 40;
  localparam int EXP_UPDATES    = 2;
  localparam int EXP_READIES    = 9;
`else
  localparam int EXP_FIRST_DISP = 50;
  localparam int EXP_UPDATES    = 1;
  localparam int EXP_READIES    = 10;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       disp_word;
  logic              disp_update;

  logic [31:0] mem [16] = '{0: 32'h0000_0005, default: 32'h0};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -4;

  dmem_arbiter #(
    .ADDR_W         (ADDR_W),
    .REFRESH_CYCLES (16),
    .STARVE_LIMIT   (8),
    .DISP_ADDR      (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .disp_word   (disp_word),
    .disp_update (disp_update)
  );

  always #5 clk = ~clk;

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata     <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the middle of the next cycle.
  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int early_en;
    int first_disp;
    int n_upd;
    int n_rdy;
    int n_bad;
    int base;
    int rel_upd;
    logic [31:0] word_at_upd;
    int post_rdy;

    reset     = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd7;
    cpu_wdata = 32'hAAAA_5555;

    // While in reset a pending CPU request must not reach the memory.
    next_cycle(); next_cycle(); next_cycle();
    #1 check("rst_mem_en", {31'b0, mem_en}, 32'd0);

    // Cycle 0: first cycle out of reset.
    next_cycle();
    reset   = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rst_cpu_ready",   {31'b0, cpu_ready},   32'd0);
    check("rst_cpu_rdata",   cpu_rdata,            32'd0);
    check("rst_disp_word",   disp_word,            32'd0);
    check("rst_disp_update", {31'b0, disp_update}, 32'd0);

    // No memory traffic until the first refresh.
    early_en = 0;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      #1 if (mem_en) early_en++;
    end
    check("quiet_before_refresh", early_en, 0);

    next_cycle();  // cycle 16
    #1;
    check("refresh_mem_en",   {31'b0, mem_en}, 32'd1);
    check("refresh_mem_addr", {28'b0, mem_addr}, 32'd0);
    check("refresh_mem_we",   {31'b0, mem_we}, 32'd0);

    next_cycle();  // cycle 17
    #1;
    check("refresh_update", {31'b0, disp_update}, 32'd1);
    check("refresh_word",   disp_word, 32'h0000_0005);

    next_cycle();  // cycle 18: pulse is one cycle; issue a store
    #1 check("update_one_cycle", {31'b0, disp_update}, 32'd0);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd3;
    cpu_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_mem_en",    {31'b0, mem_en}, 32'd1);
    check("st_mem_we",    {31'b0, mem_we}, 32'd1);
    check("st_mem_addr",  {28'b0, mem_addr}, 32'd3);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);

    next_cycle();  // cycle 19: completion, request still held, no regrant
    #1;
    check("st_ready",     {31'b0, cpu_ready}, 32'd1);
    check("no_regrant",   {31'b0, mem_en}, 32'd0);
    cpu_we = 1'b0;

    next_cycle();  // cycle 20: load grant
    #1;
    check("ld_mem_en",   {31'b0, mem_en}, 32'd1);
    check("ld_mem_we",   {31'b0, mem_we}, 32'd0);
    check("ld_mem_addr", {28'b0, mem_addr}, 32'd3);

    next_cycle();  // cycle 21
    #1;
    check("ld_ready", {31'b0, cpu_ready}, 32'd1);
    check("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;

    next_cycle();  // cycle 22
    #1;
    check("idle_ready", {31'b0, cpu_ready}, 32'd0);
    check("idle_mem_en", {31'b0, mem_en}, 32'd0);

    // Back-to-back CPU loads across two refresh wraps (end of cycles 31, 47).
    while (cyc < 29) next_cycle();
    first_disp = -1;
    n_upd = 0;
    n_rdy = 0;
    n_bad = 0;
    for (int c = 30; c <= 61; c++) begin
      next_cycle();
      if (cyc == 30) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 4'd3;
      end
      #1;
      if (mem_en && (mem_addr == 4'd0) && (first_disp < 0)) first_disp = cyc;
      if (disp_update) n_upd++;
      if (cpu_ready) begin
        n_rdy++;
        if (cpu_rdata !== 32'hDEAD_BEEF) n_bad++;
      end
      if (cyc == 49) cpu_req = 1'b0;
    end
    check("starve_first_disp", first_disp, EXP_FIRST_DISP);
    check("starve_updates",    n_upd, EXP_UPDATES);
    check("starve_readies",    n_rdy, EXP_READIES);
    check("starve_bad_rdata",  n_bad, 0);
    check("starve_disp_word",  disp_word, 32'h0000_0005);

    // Store to the display address is only visible after the next refresh.
    next_cycle();  // cycle 62
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd0;
    cpu_wdata = 32'h0000_0077;
    #1 check("st0_mem_en", {31'b0, mem_en}, 32'd1);

    next_cycle();  // cycle 63
    #1;
    check("st0_ready",        {31'b0, cpu_ready}, 32'd1);
    check("st0_not_forwarded", disp_word, 32'h0000_0005);
    cpu_req = 1'b0;

    next_cycle();  // cycle 64: refresh fetch
    #1;
    check("refresh2_mem_en",   {31'b0, mem_en}, 32'd1);
    check("refresh2_mem_addr", {28'b0, mem_addr}, 32'd0);

    next_cycle();  // cycle 65
    #1;
    check("refresh2_update", {31'b0, disp_update}, 32'd1);
    check("refresh2_word",   disp_word, 32'h0000_0077);

    // Reset arriving in a CPU grant cycle abandons the access.
    next_cycle();  // cycle 66
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 4'd5;
    cpu_wdata = 32'h0000_1234;
    #1 check("grant_before_rst", {31'b0, mem_en}, 32'd1);
    reset = 1'b1;
    #1 check("grant_gated_by_rst", {31'b0, mem_en}, 32'd0);

    next_cycle();  // cycle 67
    #1;
    check("rst_mid_ready",     {31'b0, cpu_ready}, 32'd0);
    check("rst_mid_disp_word", disp_word, 32'd0);
    check("rst_mid_mem_en",    {31'b0, mem_en}, 32'd0);
    reset   = 1'b0;
    cpu_req = 1'b0;
    base    = cyc;

    // Timer restarts: the next display update lands 17 cycles after release.
    rel_upd     = -1;
    word_at_upd = '0;
    post_rdy    = 0;
    for (int c = 1; c <= 22; c++) begin
      next_cycle();
      #1;
      if (cpu_ready) post_rdy++;
      if (disp_update && (rel_upd < 0)) begin
        rel_upd     = cyc - base;
        word_at_upd = disp_word;
      end
    end
    check("post_rst_no_ready",   post_rdy, 0);
    check("post_rst_update_at",  rel_upd, 17);
    check("post_rst_disp_word",  word_at_upd, 32'h0000_0077);
    check("store_abandoned",     mem[5], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
